// File: rtl/wb_prefetch.sv
`default_nettype none
// ============================================================================
// wb_prefetch : sequential instruction prefetch buffer on a pipelined Wishbone
//               read port, presenting words to the fetch unit via valid/ready
// Revision    : 1.0
// ============================================================================
module wb_prefetch #(
  parameter int DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        bus_cyc_o,
  output logic        bus_stb_o,
  output logic [31:0] bus_adr_o,
  output logic        bus_we_o,
  output logic [3:0]  bus_sel_o,
  output logic [31:0] bus_dat_o,
  input  logic [31:0] bus_dat_i,
  input  logic        bus_ack_i,
  input  logic        bus_stall_i,
  input  logic        flush_i,
  input  logic [31:0] flush_adr_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [31:0] data_o,
  output logic [31:0] adr_o
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t        state_q;
  logic [31:0]   req_adr_q;
  logic [31:0]   head_adr_q;
  logic [31:0]   fifo_q [DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] pend_q, pend_d;
  logic [CW-1:0] drop_q, drop_d;

  logic [CW:0]   inflight;
  logic          req_go;
  logic          ack_any;
  logic          ack_live;
  logic          ack_stale;
  logic          pop;
  logic [31:0]   flush_base;
  logic          unused_adr_bits;

  assign flush_base      = {flush_adr_i[31:2], 2'b00};
  assign unused_adr_bits = ^flush_adr_i[1:0];

  // Credit uses registered state only, so a pop frees its slot a cycle later.
  assign inflight  = {1'b0, pend_q} + {1'b0, count_q};
  assign bus_stb_o = (state_q == RUN) & ~flush_i & (inflight < DEPTH_W);
  assign bus_cyc_o = bus_stb_o | (pend_q != '0) | (drop_q != '0);
  assign bus_adr_o = req_adr_q;
  assign bus_we_o  = 1'b0;
  assign bus_sel_o = 4'hF;
  assign bus_dat_o = 32'h0;

  assign req_go    = bus_stb_o & ~bus_stall_i;
  assign ack_any   = bus_ack_i & ((drop_q != '0) | (pend_q != '0));
  assign ack_stale = bus_ack_i & (drop_q != '0);
  assign ack_live  = bus_ack_i & (drop_q == '0) & (pend_q != '0);
  assign pop       = valid_o & ready_i;

  assign valid_o = (count_q != '0);
  assign data_o  = fifo_q[rd_ptr_q];
  assign adr_o   = head_adr_q;

  always_comb begin
    count_d = count_q;
    pend_d  = pend_q;
    drop_d  = drop_q;
    if (flush_i) begin
      // Everything still in flight becomes stale; an ack right now is one of them.
      drop_d  = drop_q + pend_q - CW'(ack_any);
      pend_d  = '0;
      count_d = '0;
    end else begin
      pend_d  = pend_q + CW'(req_go) - CW'(ack_live);
      drop_d  = drop_q - CW'(ack_stale);
      count_d = count_q + CW'(ack_live) - CW'(pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      req_adr_q  <= 32'h0;
      head_adr_q <= 32'h0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      pend_q     <= '0;
      drop_q     <= '0;
    end else begin
      count_q <= count_d;
      pend_q  <= pend_d;
      drop_q  <= drop_d;
      if (flush_i) begin
        state_q    <= RUN;
        req_adr_q  <= flush_base;
        head_adr_q <= flush_base;
        wr_ptr_q   <= '0;
        rd_ptr_q   <= '0;
      end else begin
        if (req_go) begin
          req_adr_q <= req_adr_q + 32'd4;
        end
        if (ack_live) begin
          wr_ptr_q <= wr_ptr_q + 1'b1;
        end
        if (pop) begin
          rd_ptr_q   <= rd_ptr_q + 1'b1;
          head_adr_q <= head_adr_q + 32'd4;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!flush_i && ack_live) begin
      fifo_q[wr_ptr_q] <= bus_dat_i;
    end
  end

endmodule
`default_nettype wire
